// File: rtl/iic_pkg.sv
// Purpose: shared types and constants for the I2C register-write controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package iic_pkg;

  // Controller states. The five phase states run in this order.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_CHIP,
    ST_REG,
    ST_DATA,
    ST_STOP,
    ST_GAP
  } state_e;

  localparam int GAP_CYCLES_DEF = 20;
  localparam int TIMEOUT_DEF    = 255;

  // Value driven on data_out whenever no byte phase is active.
  localparam logic [7:0] IDLE_DATA = 8'hFF;

  // True in the states that wait on a transmitter finish input.
  function automatic logic is_phase(state_e s);
    return (s == ST_START) || (s == ST_CHIP) || (s == ST_REG) ||
           (s == ST_DATA)  || (s == ST_STOP);
  endfunction

endpackage

// File: rtl/iic_wr_ctrl_if.sv
// Purpose: command-side bundle of the write controller (command handshake plus status).
// Latency: n/a (wires only).
// Backpressure: cmd_valid/cmd_ready; a command moves only when both are high on a clock edge.
interface iic_wr_ctrl_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [6:0] cmd_chip;
  logic [7:0] cmd_reg;
  logic [7:0] cmd_data;
  logic       busy;
  logic       done;
  logic       err;

  // Command issuer side.
  modport master (
    output cmd_valid, cmd_chip, cmd_reg, cmd_data,
    input  cmd_ready, busy, done, err
  );

  // Controller side.
  modport slave (
    input  cmd_valid, cmd_chip, cmd_reg, cmd_data,
    output cmd_ready, busy, done, err
  );

endinterface

// File: rtl/iic_phase_timer.sv
// Purpose: saturating cycle counter that flags when a limit has been reached.
// Latency: expired reflects the registered count; clear takes effect on the next edge.
// Backpressure: none; the count holds at the limit instead of wrapping.
module iic_phase_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             expired
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: clear wins, otherwise count up while enabled and stop at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != limit)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && (cnt_q == limit);

endmodule

// File: rtl/iic_wr_ctrl.sv
// Purpose: sequences START/CHIP/REG/DATA/STOP requests for one I2C register write, then a bus-idle gap.
// Latency: START is requested the cycle after acceptance; each phase ends on the edge its finish input is seen.
// Backpressure: cmd_ready only in IDLE; a phase whose finish never arrives is abandoned after TIMEOUT clocks.
module iic_wr_ctrl
  import iic_pkg::*;
#(
  parameter int GAP_CYCLES = GAP_CYCLES_DEF,  // must be at least 1
  parameter int TIMEOUT    = TIMEOUT_DEF      // must be at least 1
) (
  input  logic                clk,
  input  logic                rst,
  iic_wr_ctrl_if.slave        cmd_if,
  output logic                trans_start,
  output logic                trans_chip,
  output logic                trans_reg,
  output logic                trans_data,
  output logic                trans_stop,
  input  logic                finish_start,
  input  logic                finish_chip,
  input  logic                finish_reg,
  input  logic                finish_data,
  input  logic                finish_stop,
  output logic [7:0]          data_out
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [TW-1:0] PHASE_LIMIT = TW'(TIMEOUT);
  // The gap counter starts at 0 on entry, so GAP_CYCLES clocks end at GAP_CYCLES-1.
  localparam logic [GW-1:0] GAP_LIMIT   = GW'(GAP_CYCLES - 1);

  state_e     state_q,    state_d;
  logic [6:0] chip_q,     chip_d;
  logic [7:0] reg_q,      reg_d;
  logic [7:0] data_q,     data_d;
  logic       err_flag_q, err_flag_d;
  logic       done_q,     done_d;
  logic       err_q,      err_d;

  logic       state_chg;
  logic       phase_exp;
  logic       gap_exp;

  // Both timers restart whenever the state changes.
  assign state_chg = (state_d != state_q);

  iic_phase_timer #(.WIDTH(TW)) u_phase_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_chg),
    .enable  (is_phase(state_q)),
    .limit   (PHASE_LIMIT),
    .expired (phase_exp)
  );

  iic_phase_timer #(.WIDTH(GW)) u_gap_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_chg),
    .enable  (state_q == ST_GAP),
    .limit   (GAP_LIMIT),
    .expired (gap_exp)
  );

  // Next state, command latch and completion pulses; a finish input beats a same-cycle timeout.
  always_comb begin
    state_d    = state_q;
    chip_d     = chip_q;
    reg_d      = reg_q;
    data_d     = data_q;
    err_flag_d = err_flag_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_if.cmd_valid) begin
          chip_d     = cmd_if.cmd_chip;
          reg_d      = cmd_if.cmd_reg;
          data_d     = cmd_if.cmd_data;
          err_flag_d = 1'b0;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        if (finish_start) begin
          state_d = ST_CHIP;
        end else if (phase_exp) begin
          state_d    = ST_STOP;
          err_flag_d = 1'b1;
        end
      end
      ST_CHIP: begin
        if (finish_chip) begin
          state_d = ST_REG;
        end else if (phase_exp) begin
          state_d    = ST_STOP;
          err_flag_d = 1'b1;
        end
      end
      ST_REG: begin
        if (finish_reg) begin
          state_d = ST_DATA;
        end else if (phase_exp) begin
          state_d    = ST_STOP;
          err_flag_d = 1'b1;
        end
      end
      ST_DATA: begin
        if (finish_data) begin
          state_d = ST_STOP;
        end else if (phase_exp) begin
          state_d    = ST_STOP;
          err_flag_d = 1'b1;
        end
      end
      ST_STOP: begin
        if (finish_stop) begin
          state_d = ST_GAP;
          done_d  = 1'b1;
          err_d   = err_flag_q;
        end else if (phase_exp) begin
          state_d    = ST_GAP;
          done_d     = 1'b1;
          err_d      = 1'b1;
          err_flag_d = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_exp) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, latched command and pulse registers; reset drops any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      chip_q     <= '0;
      reg_q      <= '0;
      data_q     <= '0;
      err_flag_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      chip_q     <= chip_d;
      reg_q      <= reg_d;
      data_q     <= data_d;
      err_flag_q <= err_flag_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Moore decode of the phase requests and the transmitter byte.
  always_comb begin
    trans_start = 1'b0;
    trans_chip  = 1'b0;
    trans_reg   = 1'b0;
    trans_data  = 1'b0;
    trans_stop  = 1'b0;
    data_out    = IDLE_DATA;
    case (state_q)
      ST_START: trans_start = 1'b1;
      ST_CHIP: begin
        trans_chip = 1'b1;
        data_out   = {chip_q, 1'b0};
      end
      ST_REG: begin
        trans_reg = 1'b1;
        data_out  = reg_q;
      end
      ST_DATA: begin
        trans_data = 1'b1;
        data_out   = data_q;
      end
      ST_STOP: trans_stop = 1'b1;
      default: ;
    endcase
  end

  assign cmd_if.cmd_ready = (state_q == ST_IDLE);
  assign cmd_if.busy      = (state_q != ST_IDLE);
  assign cmd_if.done      = done_q;
  assign cmd_if.err       = err_q;

endmodule

// File: tb/tb_iic_wr_ctrl.sv
// Purpose: directed self-checking bench for iic_wr_ctrl with a reactive transmitter model.
// Latency: n/a.
// Backpressure: n/a.
module tb_iic_wr_ctrl;

  localparam int GAP = 8;
  localparam int TO  = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic trans_start, trans_chip, trans_reg, trans_data, trans_stop;
  logic finish_start = 1'b0, finish_chip = 1'b0, finish_reg = 1'b0;
  logic finish_data = 1'b0, finish_stop = 1'b0;
  logic [7:0] data_out;

  iic_wr_ctrl_if cmd_if ();

  iic_wr_ctrl #(.GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_if       (cmd_if),
    .trans_start  (trans_start),
    .trans_chip   (trans_chip),
    .trans_reg    (trans_reg),
    .trans_data   (trans_data),
    .trans_stop   (trans_stop),
    .finish_start (finish_start),
    .finish_chip  (finish_chip),
    .finish_reg   (finish_reg),
    .finish_data  (finish_data),
    .finish_stop  (finish_stop),
    .data_out     (data_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Per-transaction observations filled in by run_txn.
  logic [7:0] cap [3];
  int         ph_len [5];
  logic [4:0] seen;
  int         done_cnt, err_at_done, err_stray, gap_len, onehot_bad, order_bad;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] trans_vec();
    return {trans_stop, trans_data, trans_reg, trans_chip, trans_start};
  endfunction

  // mode: 0 normal, 1 finish_reg withheld, 2 finish_data on the timeout cycle,
  //       3 stray finish_stop during CHIP, 4 reset pulse during DATA.
  task automatic run_txn(input logic [6:0] c, input logic [7:0] r, input logic [7:0] d,
                         input int mode, input logic hold_valid,
                         input logic [6:0] nc, input logic [7:0] nr, input logic [7:0] nd);
    int         prev, cyc, ph, t_done;
    logic [4:0] tr, fin;
    logic       finished;
    for (int i = 0; i < 3; i++) cap[i] = 8'hFF;
    for (int i = 0; i < 5; i++) ph_len[i] = 0;
    seen = '0; done_cnt = 0; err_at_done = 0; err_stray = 0; gap_len = -1;
    onehot_bad = 0; order_bad = 0;
    prev = -1; cyc = 0; t_done = 0; finished = 1'b0;

    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_chip  = c;
    cmd_if.cmd_reg   = r;
    cmd_if.cmd_data  = d;
    step();
    if (hold_valid) begin
      cmd_if.cmd_chip = nc;
      cmd_if.cmd_reg  = nr;
      cmd_if.cmd_data = nd;
    end else begin
      cmd_if.cmd_valid = 1'b0;
    end

    for (int t = 0; t < 400 && !finished; t++) begin
      tr = trans_vec();
      if ($countones(tr) > 1) onehot_bad++;
      ph = -1;
      for (int i = 0; i < 5; i++) if (tr[i]) ph = i;
      if (ph >= 0) begin
        if (ph != prev) begin
          if (ph < prev) order_bad++;
          cyc = 0;
          seen[ph] = 1'b1;
          if (ph >= 1 && ph <= 3) cap[ph-1] = data_out;
          prev = ph;
        end else begin
          cyc++;
        end
        ph_len[ph]++;
      end
      if (cmd_if.done) begin
        done_cnt++;
        err_at_done = int'(cmd_if.err);
        t_done = t;
      end else if (cmd_if.err) begin
        err_stray++;
      end
      if (done_cnt > 0 && cmd_if.cmd_ready) begin
        gap_len  = t - t_done;
        finished = 1'b1;
      end else if (mode == 4 && ph == 3 && cyc == 1) begin
        {finish_stop, finish_data, finish_reg, finish_chip, finish_start} = '0;
        rst = 1'b1;
        step();
        check_eq("rst_trans_low", 32'(trans_vec()), 32'h0);
        check_eq("rst_no_done", 32'(cmd_if.done), 32'h0);
        check_eq("rst_data_out", 32'(data_out), 32'hFF);
        rst = 1'b0;
        step();
        check_eq("rst_ready_after", 32'(cmd_if.cmd_ready), 32'h1);
        check_eq("rst_not_busy", 32'(cmd_if.busy), 32'h0);
        finished = 1'b1;
      end else begin
        fin = '0;
        if (ph >= 0) begin
          if (!(mode == 1 && ph == 2) && !(mode == 2 && ph == 3) && cyc == 2) fin[ph] = 1'b1;
          if (mode == 2 && ph == 3 && cyc == TO) fin[3] = 1'b1;
          if (mode == 3 && ph == 1 && cyc == 0) fin[4] = 1'b1;
        end
        {finish_stop, finish_data, finish_reg, finish_chip, finish_start} = fin;
        step();
      end
    end
    {finish_stop, finish_data, finish_reg, finish_chip, finish_start} = '0;
    if (!finished) check_eq("txn_cycle_budget", 32'h0, 32'h1);
  endtask

  task automatic check_normal(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2);
    check_eq({tag, "_chip_byte"}, 32'(cap[0]), 32'(e0));
    check_eq({tag, "_reg_byte"},  32'(cap[1]), 32'(e1));
    check_eq({tag, "_data_byte"}, 32'(cap[2]), 32'(e2));
    check_eq({tag, "_phases"},    32'(seen), 32'h1F);
    check_eq({tag, "_onehot"},    32'(onehot_bad), 32'h0);
    check_eq({tag, "_order"},     32'(order_bad), 32'h0);
    check_eq({tag, "_done_cnt"},  32'(done_cnt), 32'h1);
    check_eq({tag, "_err"},       32'(err_at_done), 32'h0);
    check_eq({tag, "_gap"},       32'(gap_len), 32'(GAP));
  endtask

  initial begin
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_chip  = '0;
    cmd_if.cmd_reg   = '0;
    cmd_if.cmd_data  = '0;
    rst = 1'b1;
    step();
    step();
    check_eq("reset_trans", 32'(trans_vec()), 32'h0);
    check_eq("reset_done", 32'(cmd_if.done), 32'h0);
    check_eq("reset_err", 32'(cmd_if.err), 32'h0);
    check_eq("reset_data_out", 32'(data_out), 32'hFF);
    check_eq("reset_busy", 32'(cmd_if.busy), 32'h0);
    rst = 1'b0;
    step();
    check_eq("idle_ready", 32'(cmd_if.cmd_ready), 32'h1);

    // Plain write: chip 0x50 -> address byte 0xA0.
    run_txn(7'h50, 8'h12, 8'hA5, 0, 1'b0, '0, '0, '0);
    check_normal("normal", 8'hA0, 8'h12, 8'hA5);
    check_eq("normal_err_stray", 32'(err_stray), 32'h0);
    check_eq("normal_stop_len", 32'(ph_len[4]), 32'h3);

    // Back-to-back: inputs switch to the second command while the first is in flight.
    run_txn(7'h50, 8'h12, 8'hA5, 0, 1'b1, 7'h2A, 8'hC3, 8'h5E);
    check_normal("b2b_first", 8'hA0, 8'h12, 8'hA5);
    run_txn(7'h2A, 8'hC3, 8'h5E, 0, 1'b0, '0, '0, '0);
    check_normal("b2b_second", 8'h54, 8'hC3, 8'h5E);

    // REG never finishes: REG held TO+1 cycles, then STOP, done with err.
    run_txn(7'h21, 8'h34, 8'h56, 1, 1'b0, '0, '0, '0);
    check_eq("tmo_reg_len", 32'(ph_len[2]), 32'(TO + 1));
    check_eq("tmo_phases", 32'(seen), 32'h17);
    check_eq("tmo_done_cnt", 32'(done_cnt), 32'h1);
    check_eq("tmo_err", 32'(err_at_done), 32'h1);
    check_eq("tmo_err_stray", 32'(err_stray), 32'h0);
    check_eq("tmo_gap", 32'(gap_len), 32'(GAP));

    // finish_data lands on the same cycle the timer expires: finish wins.
    run_txn(7'h11, 8'h22, 8'h33, 2, 1'b0, '0, '0, '0);
    check_eq("race_data_len", 32'(ph_len[3]), 32'(TO + 1));
    check_normal("race", 8'h22, 8'h22, 8'h33);

    // Stray finish_stop during CHIP is ignored.
    run_txn(7'h50, 8'h12, 8'hA5, 3, 1'b0, '0, '0, '0);
    check_eq("spur_chip_len", 32'(ph_len[1]), 32'h3);
    check_normal("spur", 8'hA0, 8'h12, 8'hA5);

    // Reset during DATA abandons the write without a done pulse.
    run_txn(7'h7F, 8'hFF, 8'h00, 4, 1'b0, '0, '0, '0);
    check_eq("rstmid_done_cnt", 32'(done_cnt), 32'h0);

    // Controller recovers cleanly after the mid-transaction reset.
    run_txn(7'h0C, 8'h9A, 8'hBC, 0, 1'b0, '0, '0, '0);
    check_normal("recover", 8'h18, 8'h9A, 8'hBC);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/iic_wr_ctrl.md
IIC_WR_CTRL -- requirements
Module: iic_wr_ctrl

Interface
REQ-001 Parameter GAP_CYCLES, default 20: idle clocks enforced between the end of STOP and the next command acceptance.
REQ-002 Parameter TIMEOUT, default 255: maximum clocks a phase waits for its finish input before the phase is abandoned.
REQ-003 clk  input  1  sole clock; all state changes on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  1  write command offered.
REQ-006 cmd_ready  output  1  block can accept a command this cycle.
REQ-007 cmd_chip  input  7  7-bit target address.
REQ-008 cmd_reg  input  8  register address byte.
REQ-009 cmd_data  input  8  data byte.
REQ-010 busy  output  1  transaction in progress (any state but IDLE).
REQ-011 done  output  1  one-cycle pulse at transaction end.
REQ-012 err  output  1  one-cycle pulse coincident with done when any phase timed out.
REQ-013 trans_start, trans_chip, trans_reg, trans_data, trans_stop  output  1 each  phase requests to the bit-level transmitter.
REQ-014 finish_start, finish_chip, finish_reg, finish_data, finish_stop  input  1 each  phase-complete indications from the transmitter.
REQ-015 data_out  output  8  byte presented to the transmitter data input.

Function
REQ-016 The FSM SHALL have states IDLE, START, CHIP, REG, DATA, STOP, GAP.
REQ-017 cmd_ready SHALL be high only in IDLE; a command SHALL be accepted when cmd_valid and cmd_ready are both high on a clock edge.
REQ-018 On acceptance, cmd_chip, cmd_reg and cmd_data SHALL be latched, and the state SHALL be START on the next cycle.
REQ-019 trans_* SHALL be Moore-decoded from the state register, one-hot, and high only in the matching state; all SHALL be low in IDLE and GAP.
REQ-020 The phase order SHALL be START -> CHIP -> REG -> DATA -> STOP.
  - Each transition occurs on the edge where the current phase's finish input is high.
  - A finish input for a phase other than the current one SHALL be ignored.
REQ-021 data_out SHALL be:
  - {chip,1'b0} in CHIP
  - the latched reg byte in REG
  - the latched data byte in DATA
  - 8'hFF in all other states.
REQ-022 In STOP, on finish_stop, done SHALL pulse for exactly one cycle and the state SHALL move to GAP.
REQ-023 GAP SHALL last exactly GAP_CYCLES clocks, then the state SHALL return to IDLE.
REQ-024 A per-phase counter SHALL clear on every state entry and increment each cycle in START, CHIP, REG, DATA and STOP.
REQ-025 If the counter reaches TIMEOUT in START, CHIP, REG or DATA, the FSM SHALL go to STOP and set an internal error flag.
REQ-026 If the counter reaches TIMEOUT in STOP, the FSM SHALL go to GAP, pulse done, and set the error flag.
REQ-027 err SHALL pulse together with done when the error flag is set; the error flag SHALL clear on command acceptance.
REQ-028 If a finish input and the timeout occur in the same cycle, the finish input SHALL win (normal transition, no error).
REQ-029 Latched command bytes SHALL NOT change while busy; cmd_* inputs SHALL be ignored while busy.
REQ-030 The GAP and phase counters SHALL be sized to hold GAP_CYCLES and TIMEOUT and SHALL saturate, never wrap.

Reset
REQ-031 While rst is high, on each clock:
  - state SHALL be IDLE, with all trans_* low
  - done and err SHALL be low
  - data_out SHALL be 8'hFF
  - counters and the error flag SHALL be cleared.
REQ-032 rst asserted mid-transaction SHALL abandon the transaction immediately, with no STOP and no done pulse; cmd_ready SHALL be high on the first cycle after rst deasserts.

Structure
REQ-033 Shared package iic_pkg SHALL hold:
  - the state enumeration
  - default GAP_CYCLES and TIMEOUT constants
  - the idle data constant 8'hFF.
REQ-034 The per-phase timeout counter SHALL be a sub-module named iic_phase_timer, with inputs clear, enable and limit, and output expired.

Verification
REQ-035 Normal write: chip=7'h50, reg=8'h12, data=8'hA5, with a transmitter model.
  - data_out sequence SHALL be A0, 12, A5.
  - trans_* SHALL be strictly one-hot in order.
  - done SHALL pulse once with err=0.
  - cmd_ready SHALL rise GAP_CYCLES clocks after done.
REQ-036 Back-to-back: cmd_valid held high with a second command.
  - The second command SHALL be accepted only after GAP.
  - Its bytes SHALL be unaffected by input changes made during the first transaction.
REQ-037 Timeout: finish_reg never asserted.
  - After TIMEOUT clocks in REG, state SHALL go to STOP and then finish.
  - done and err SHALL pulse together.
REQ-038 Race: finish_data asserted on the exact timeout cycle -> normal transition to STOP; err SHALL stay 0 at done.
REQ-039 Reset in DATA: rst held for 1 cycle -> all trans_* low next cycle, no done, cmd_ready=1 after rst drops.
REQ-040 Spurious finish: finish_stop pulsed during CHIP -> no state change; transaction completes normally.
